// File: rtl/register_dump_tx_pkg.sv
// register_dump_tx_pkg
// Shared definitions for the register dump transmitter: FSM state encoding
// and the frame header byte. Optional framing is enabled by DUMP_FRAMING_EN.
`timescale 1ns/1ps
package register_dump_tx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HEADER   = 3'd1,
        LOAD     = 3'd2,
        SEND     = 3'd3,
        CHECKSUM = 3'd4,
        DONE     = 3'd5
    } dump_state_t;

    localparam logic [7:0] DUMP_HEADER = 8'hA5;

endpackage

// File: rtl/register_dump_tx.sv
// register_dump_tx
// Debug read-out engine: on a one-cycle dump_start it freezes the pipeline,
// walks the register bank read port from 0 to NUM_REGS-1 and streams each
// word LSB-first as bytes over a valid/ready interface.
//
// Ports:
//   clk, reset_n   single clock, asynchronous active-low reset
//   dump_start     one-cycle request; ignored while a dump is running
//   halt, busy     high from the first cycle after the request until DONE
//   rd_addr        bank read address (combinational rd_data returned)
//   rd_data        bank read data
//   tx_data/valid  byte stream toward the transmitter
//   tx_ready       transmitter accepts a byte on tx_valid && tx_ready
//   done           one-cycle pulse after the final byte
//
// Macro DUMP_FRAMING_EN adds a leading 8'hA5 header byte and a trailing
// XOR checksum byte over all data bytes.
`timescale 1ns/1ps
module register_dump_tx
    import register_dump_tx_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dump_start,
    output logic                  halt,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  done
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    dump_state_t           state, state_next;
    logic [DATA_WIDTH-1:0] shift;
    logic [BCW-1:0]        byte_cnt;
`ifdef DUMP_FRAMING_EN
    logic [7:0]            csum;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are decoded from state so that reset forces them all low at once.
    always_comb begin
        state_next = state;
        halt       = 1'b0;
        busy       = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
`ifdef DUMP_FRAMING_EN
                    state_next = HEADER;
`else
                    state_next = LOAD;
`endif
                end
            end
`ifdef DUMP_FRAMING_EN
            HEADER: begin
                halt     = 1'b1;
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = DUMP_HEADER;
                if (tx_ready) state_next = LOAD;
            end
`endif
            LOAD: begin
                halt       = 1'b1;
                busy       = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                halt     = 1'b1;
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = shift[7:0];
                if (tx_ready && byte_cnt == LAST_BYTE) begin
                    if (rd_addr == LAST_ADDR) begin
`ifdef DUMP_FRAMING_EN
                        state_next = CHECKSUM;
`else
                        state_next = DONE;
`endif
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
`ifdef DUMP_FRAMING_EN
            CHECKSUM: begin
                halt     = 1'b1;
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) state_next = DONE;
            end
`endif
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift    <= '0;
            byte_cnt <= '0;
            rd_addr  <= '0;
`ifdef DUMP_FRAMING_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        rd_addr <= '0;
`ifdef DUMP_FRAMING_EN
                        csum    <= '0;
`endif
                    end
                end
                LOAD: begin
                    shift    <= rd_data;
                    byte_cnt <= '0;
                end
                SEND: begin
                    if (tx_ready) begin
                        shift    <= shift >> 8;
                        byte_cnt <= byte_cnt + 1'b1;
`ifdef DUMP_FRAMING_EN
                        csum     <= csum ^ shift[7:0];
`endif
                        // Address advances only between words and stops at the last index.
                        if (byte_cnt == LAST_BYTE && rd_addr != LAST_ADDR) begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                DONE: rd_addr <= '0;
                default: ;
            endcase
        end
    end

endmodule
